dm_port_arbiter: RTL
====================

# dm_port_arbiter

Shares the single-port 3072-word data memory between the pipeline's MEM stage and an external word-access port, for example a debug loader or test harness. It sits between the MEM-stage signals and the data memory and drives the memory's address, write data and write enable. The MEM stage has priority, but a starvation counter guarantees the external port a slot by stalling the pipeline for one cycle. Out-of-range addresses are detected, and writes to them are suppressed.

## Interface
Parameters:
- STARVE_LIMIT, default 4: the number of consecutive denied cycles after which the external port is granted ahead of the MEM stage.
- DM_WORDS, default 3072: the memory depth in words. Valid byte addresses are 0 to DM_WORDS*4-1.

Ports:
- clk, input, 1: the single clock. All state changes on posedge clk.
- reset, input, 1: synchronous, active-high reset.
- cpuMemReq, input, 1: the MEM stage has a load or store this cycle.
- cpuWrite, input, 1: the MEM-stage access is a store. Only meaningful when cpuMemReq=1.
- cpuAddr, input, 32: the MEM-stage byte address (aluOutM).
- cpuWdata, input, 32: the MEM-stage store data.
- cpuRdata, output, 32: load data returned to the MEM stage.
- cpuStall, output, 1: the MEM stage must hold this cycle.
- extReq, input, 1: external request. Held high until extGnt is seen.
- extWrite, input, 1: the external access is a write.
- extAddr, input, 32: the external byte address.
- extWdata, input, 32: the external write data.
- extGnt, output, 1: one-cycle pulse; the external access is performed in this cycle.
- extRdata, output, 32: registered read data.
- extRvalid, output, 1: one-cycle pulse one cycle after extGnt.
- extErr, output, 1: registered, with extRvalid. The granted address was out of range.
- dmAddr, output, 12: word address to the memory, taken from address bits [13:2].
- dmWdata, output, 32: write data to the memory.
- dmWrite, output, 1: write enable to the memory.
- dmRdata, input, 32: combinational read data from the memory.

## Operation
- The arbiter has two states:
  - **CPU** (the reset state): the MEM stage owns the memory.
  - **FORCE**: the external port owns the memory and the MEM stage is stalled.
- waitCnt is a 3-bit or wider counter that saturates at STARVE_LIMIT.
  - It increments each cycle in which extReq=1 and extGnt=0.
  - It clears on extGnt, and whenever extReq=0.
- Grant rules in state CPU (combinational):
  - If cpuMemReq=0 and extReq=1, then extGnt=1. This is an opportunistic grant; no stall.
  - Otherwise the MEM stage is served and extGnt=0.
- Transition CPU→FORCE happens on the edge at which waitCnt reaches STARVE_LIMIT while extReq=1 is still held.
- Behaviour in FORCE:
  - extGnt=1.
  - cpuStall=1, but only if cpuMemReq=1.
  - The next state is always CPU. FORCE lasts exactly one cycle.
- Memory mux:
  - The granted requester drives dmAddr, dmWdata and the qualified write.
  - When neither requester is active, dmAddr follows cpuAddr[13:2] and dmWrite=0.
- Range check: an address is out of range if addr[31:2] >= DM_WORDS.
  - Any write to an out-of-range address is suppressed (dmWrite=0).
  - Reads from out-of-range addresses return 0.
  - For the external port, an out-of-range access sets extErr alongside extRvalid.
  - The MEM stage gets no error signal; its out-of-range store is silently dropped.
- Return paths:
  - cpuRdata = dmRdata when the MEM stage is served; otherwise it is 0.
  - extRdata/extRvalid/extErr are captured at the grant edge.
- Reset mid-operation:
  - State returns to CPU and waitCnt=0.
  - extRvalid and extErr clear, and extRdata=0.
  - A grant in the reset cycle performs no write.
  - The external requester must re-present its request.

## Timing
- Reset values: cpuStall=0, extGnt=0, extRvalid=0, extErr=0, extRdata=0, cpuRdata=0, dmWrite=0.
- MEM-stage access latency is 0 cycles: the read is combinational and the write is committed at the same edge.
- External read latency:
  - extGnt is in cycle N.
  - extRvalid/extRdata follow in cycle N+1.
  - The external write is committed at the edge ending cycle N.
- Worst-case external wait: STARVE_LIMIT+1 cycles from extReq rising to extGnt.
- cpuStall never asserts for two consecutive cycles. After FORCE, the MEM stage is served first, even if extReq stays high, because waitCnt restarts from 0.
- Simultaneous events:
  - extReq dropping while in FORCE is illegal for the requester. The arbiter still grants, and the write is suppressed because extReq=0.
  - A same-cycle cpuMemReq and FORCE always goes to the external port.

## Test plan
1. Reset, then idle for 3 cycles. All outputs hold their reset values; dmWrite=0 throughout.
2. cpuMemReq=1 store of 0xDEADBEEF to address 0x10, with extReq=0. dmWrite=1 and dmAddr=4; a load from 0x10 on the next cycle gives cpuRdata=0xDEADBEEF with cpuStall=0.
3. cpuMemReq=0 and an external read from 0x10. extGnt is asserted in the same cycle; the next cycle gives extRvalid=1, extRdata=0xDEADBEEF and extErr=0.
4. cpuMemReq held at 1 and extReq held at 1 (with STARVE_LIMIT=4). extGnt first appears 5 cycles after extReq rises, with cpuStall=1 for exactly that cycle. The following cycle has cpuStall=0 and the MEM stage served.
5. External write to 0x3000 (word 3072). dmWrite=0, then extErr=1 with extRvalid. A MEM-stage store to 0xFFFC followed by a load returns cpuRdata=0.
6. Assert reset in the cycle after a FORCE grant. extRvalid is 0 the next cycle, state is back to CPU, and waitCnt restarts, so the next forced grant again takes 5 cycles.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - shares the data memory between the MEM stage and an external word port
// MEM stage wins by default; a starvation counter forces one external slot after STARVE_LIMIT denials.
module dm_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int DM_WORDS     = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpuMemReq,
  input  logic        cpuWrite,
  input  logic [31:0] cpuAddr,
  input  logic [31:0] cpuWdata,
  output logic [31:0] cpuRdata,
  output logic        cpuStall,
  input  logic        extReq,
  input  logic        extWrite,
  input  logic [31:0] extAddr,
  input  logic [31:0] extWdata,
  output logic        extGnt,
  output logic [31:0] extRdata,
  output logic        extRvalid,
  output logic        extErr,
  output logic [11:0] dmAddr,
  output logic [31:0] dmWdata,
  output logic        dmWrite,
  input  logic [31:0] dmRdata
);

  localparam int CW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  localparam logic [29:0] WORDS = 30'(DM_WORDS);

  typedef enum logic {CPU = 1'b0, FORCE = 1'b1} stateT;

  stateT         state;
  logic [CW-1:0] waitCnt;
  logic [CW-1:0] waitInc;
  logic          cpuInRange;
  logic          extInRange;
  logic          cpuServed;
  logic          unusedBits;

  assign cpuInRange = cpuAddr[31:2] < WORDS;
  assign extInRange = extAddr[31:2] < WORDS;
  assign waitInc    = (waitCnt == LIMIT) ? waitCnt : waitCnt + CW'(1);
  assign unusedBits = ^{cpuAddr[1:0], extAddr[1:0]};

  always_comb begin
    extGnt    = (state == FORCE) | (extReq & ~cpuMemReq);
    cpuStall  = (state == FORCE) & cpuMemReq;
    cpuServed = cpuMemReq & ~extGnt;
    if (extGnt) begin
      dmAddr  = extAddr[13:2];
      dmWdata = extWdata;
      // a forced grant to a requester that already dropped extReq must not write
      dmWrite = extReq & extWrite & extInRange & ~reset;
    end else begin
      dmAddr  = cpuAddr[13:2];
      dmWdata = cpuWdata;
      dmWrite = cpuMemReq & cpuWrite & cpuInRange & ~reset;
    end
    cpuRdata = (cpuServed & cpuInRange) ? dmRdata : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CPU;
      waitCnt   <= '0;
      extRvalid <= 1'b0;
      extErr    <= 1'b0;
      extRdata  <= 32'h0;
    end else begin
      extRvalid <= extGnt;
      extErr    <= extGnt & ~extInRange;
      if (extGnt) extRdata <= extInRange ? dmRdata : 32'h0;
      waitCnt <= (extGnt | ~extReq) ? '0 : waitInc;
      // FORCE lasts one cycle; waitCnt restarts so the MEM stage is served right after
      state <= (state == CPU && extReq && !extGnt && waitInc == LIMIT) ? FORCE : CPU;
    end
  end

endmodule
